// File: rtl/i281_pkg.sv
// Shared i281 constants and the code-loader state encoding.
// The width constants are also used by the bank ROM images and the IMem.
package i281_pkg;

  localparam int I281_DATA_W    = 16;
  localparam int I281_ADDR_W    = 4;
  localparam int I281_NUM_WORDS = 2 ** I281_ADDR_W;
  localparam int I281_BANK_W    = 2;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_FILL   = 3'd1,
    LD_VERIFY = 3'd2,
    LD_DONE   = 3'd3,
    LD_ERROR  = 3'd4
  } loader_state_t;

  // True while the loader owns the IMem write/readback path.
  function automatic logic loader_busy(input loader_state_t st);
    return (st == LD_FILL) || (st == LD_VERIFY);
  endfunction

endpackage

// File: rtl/i281_code_loader.sv
// i281 program loader: copies one constant ROM bank into the writable
// instruction memory, optionally reads it back to verify, and keeps the
// CPU stalled from the cycle after a load is accepted until it completes.
module i281_code_loader
  import i281_pkg::*;
#(
  parameter int DATA_W    = I281_DATA_W,
  parameter int ADDR_W    = I281_ADDR_W,
  parameter int BANK_W    = I281_BANK_W,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Load_Start,
  input  logic [BANK_W-1:0] Bank_Sel,
  output logic [BANK_W-1:0] Rom_Bank,
  output logic [ADDR_W-1:0] Rom_Addr,
  input  logic [DATA_W-1:0] Rom_Data,
  output logic              IMem_WrEn,
  output logic [ADDR_W-1:0] IMem_Addr,
  output logic [DATA_W-1:0] IMem_WrData,
  input  logic [DATA_W-1:0] IMem_RdData,
  output logic              Cpu_Hold,
  output logic              Load_Busy,
  output logic              Load_Done,
  output logic              Load_Err,
  output logic [ADDR_W-1:0] Err_Addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [BANK_W-1:0] r_bank;
  logic [BANK_W-1:0] w_bank_nxt;
  logic [ADDR_W-1:0] r_err_addr;
  logic [ADDR_W-1:0] w_err_addr_nxt;
  logic              w_last;
  logic              w_mismatch;

  assign w_last     = (r_cnt == LAST_ADDR);
  assign w_mismatch = (IMem_RdData != Rom_Data);

  // Next-state, counter, bank latch and error-address decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bank_nxt     = r_bank;
    w_err_addr_nxt = r_err_addr;
    case (r_state)
      LD_IDLE, LD_ERROR: begin
        // A new start (also the only way out of ERROR) relatches the bank
        // and wipes any previous error report.
        if (Load_Start) begin
          w_bank_nxt     = Bank_Sel;
          w_cnt_nxt      = '0;
          w_err_addr_nxt = '0;
          w_state_nxt    = LD_FILL;
        end
      end
      LD_FILL: begin
        // Counter wraps naturally to 0 after the last word, ready for readback.
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (w_last) begin
          if (VERIFY_EN) w_state_nxt = LD_VERIFY;
          else           w_state_nxt = LD_DONE;
        end
      end
      LD_VERIFY: begin
        if (w_mismatch) begin
          // Stop at the first bad word; later words are not examined.
          w_err_addr_nxt = r_cnt;
          w_cnt_nxt      = '0;
          w_state_nxt    = LD_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
          if (w_last) w_state_nxt = LD_DONE;
        end
      end
      LD_DONE: begin
        w_state_nxt = LD_IDLE;
      end
      default: begin
        w_state_nxt = LD_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, word counter, latched bank and error address registers.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state    <= LD_IDLE;
      r_cnt      <= '0;
      r_bank     <= '0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bank     <= w_bank_nxt;
      r_err_addr <= w_err_addr_nxt;
    end
  end

  // Outputs decode straight from registers, so Cpu_Hold is glitch-free and
  // rises exactly one cycle after the start is accepted.
  always_comb begin
    Rom_Bank    = r_bank;
    Rom_Addr    = r_cnt;
    IMem_Addr   = r_cnt;
    IMem_WrEn   = (r_state == LD_FILL);
    IMem_WrData = (r_state == LD_FILL) ? Rom_Data : '0;
    Cpu_Hold    = (r_state != LD_IDLE);
    Load_Busy   = loader_busy(r_state);
    Load_Done   = (r_state == LD_DONE);
    Load_Err    = (r_state == LD_ERROR);
    Err_Addr    = (r_state == LD_ERROR) ? r_err_addr : '0;
  end

endmodule
